// File: rtl/bp_be_dcache_trace_checker.sv
// Response-side trace checker: buffers dcache load responses and compares them in
// order against a per-port trace ROM, tracking check/mismatch counts and sticky errors.
module bp_be_dcache_trace_checker #(
  parameter int dword_width_p    = 64,
  parameter int rom_addr_width_p = 20,
  parameter int fifo_els_p       = 8,
  parameter int count_width_p    = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        en_i,
  input  logic                        v_i,
  input  logic [dword_width_p-1:0]    data_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [dword_width_p+3:0]    rom_data_i,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        overflow_o,
  output logic [count_width_p-1:0]    check_count_o,
  output logic [count_width_p-1:0]    mismatch_count_o
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam logic [3:0] op_finish_lp  = 4'h0;
  localparam logic [3:0] op_compare_lp = 4'h1;
  localparam logic [3:0] op_skip_lp    = 4'h2;
  localparam logic [ptr_w_lp:0] fifo_full_lp = (ptr_w_lp+1)'(fifo_els_p);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_CHECK, S_DONE
  } state_e;

  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  state_e                      state_q, state_d;
  logic [rom_addr_width_p-1:0] ptr_q, ptr_d;
  logic [3:0]                  op_q;
  logic [dword_width_p-1:0]    exp_q;
  logic [dword_width_p-1:0]    mem_q [fifo_els_p];
  logic [ptr_w_lp-1:0]         wptr_q, rptr_q;
  logic [ptr_w_lp:0]           cnt_q;
  logic                        done_q, err_q, ovf_q;
  logic [count_width_p-1:0]    check_q, mis_q;

  logic [3:0]               rom_op;
  logic [dword_width_p-1:0] head;
  logic empty, full, pop, push_ok, ovf_evt, mismatch_evt, bad_evt, extra_evt;

  assign rom_op  = rom_data_i[dword_width_p+3:dword_width_p];
  assign head    = mem_q[rptr_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == fifo_full_lp);
  // A pop only sees registered occupancy, so a same-cycle push into an empty FIFO waits a cycle.
  assign pop     = (state_q == S_CHECK) && !empty;
  assign push_ok = v_i && (!full || pop);
  assign ovf_evt = v_i && full && !pop;

  assign mismatch_evt = pop && (op_q == op_compare_lp) && (head != exp_q);
  assign bad_evt      = (state_q == S_DECODE) && (rom_op != op_finish_lp)
                        && (rom_op != op_compare_lp) && (rom_op != op_skip_lp);
  assign extra_evt    = (state_q == S_DONE) && (v_i || !empty);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE:   if (en_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (rom_op == op_compare_lp || rom_op == op_skip_lp) state_d = S_CHECK;
        else                                                 state_d = S_DONE;
      end
      S_CHECK: begin
        if (pop) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      op_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      check_q <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == S_DECODE) op_q <= rom_op;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (pop)               check_q <= sat_inc(check_q);
      if (mismatch_evt)      mis_q   <= sat_inc(mis_q);
      if (state_d == S_DONE) done_q  <= 1'b1;
      ovf_q <= ovf_q | ovf_evt;
      err_q <= err_q | ovf_evt | mismatch_evt | bad_evt | extra_evt;
    end
  end

  // Datapath storage carries no reset; occupancy and pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push_ok)             mem_q[wptr_q] <= data_i;
    if (state_q == S_DECODE) exp_q         <= rom_data_i[dword_width_p-1:0];
  end

  assign rom_addr_o       = (state_q == S_IDLE) ? '0 : ptr_q;
  assign done_o           = done_q;
  assign error_o          = err_q;
  assign overflow_o       = ovf_q;
  assign check_count_o    = check_q;
  assign mismatch_count_o = mis_q;

endmodule

// File: tb/tb_bp_be_dcache_trace_checker.sv
// Table-driven bench for the dcache trace checker with a per-response scoreboard.
module tb_bp_be_dcache_trace_checker;
  localparam int DW = 64;
  localparam int AW = 20;
  localparam int FE = 8;
  localparam int CW = 32;
  localparam int RW = DW + 4;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          en_i = 1'b0;
  logic          v_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [AW-1:0] rom_addr_o;
  logic [RW-1:0] rom_data_i;
  logic          done_o, error_o, overflow_o;
  logic [CW-1:0] check_count_o, mismatch_count_o;

  bp_be_dcache_trace_checker #(
    .dword_width_p(DW), .rom_addr_width_p(AW), .fifo_els_p(FE), .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .done_o(done_o), .error_o(error_o),
    .overflow_o(overflow_o), .check_count_o(check_count_o), .mismatch_count_o(mismatch_count_o)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] rom_mem [16];
  always @(posedge clk) rom_data_i <= (rom_addr_o < AW'(16)) ? rom_mem[rom_addr_o[3:0]] : '0;

  typedef struct {
    logic [9:0][RW-1:0] rom;
    int                 n_rsp;
    logic [9:0][DW-1:0] rsp;
    bit                 pre_en;
    int                 gap;
    int                 e_check;
    int                 e_mis;
    bit                 e_err;
    bit                 e_ovf;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   sb_q [$];
  logic [CW-1:0] prev_cc = '0;
  logic [CW-1:0] prev_mc = '0;

  function automatic logic [RW-1:0] ent(input logic [3:0] op, input logic [DW-1:0] v);
    return {op, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each consumed response must move mismatch_count_o by exactly the bench's predicted amount.
  always @(negedge clk) begin
    if (reset_n_i && check_count_o == prev_cc + 1) begin
      if (sb_q.size() == 0) chk("sb_unexpected_check", 64'd1, 64'd0);
      else begin : pop_blk
        int e;
        e = sb_q.pop_front();
        chk("sb_mismatch_delta", 64'(mismatch_count_o - prev_mc), 64'(e));
      end
    end
    prev_cc = check_count_o;
    prev_mc = mismatch_count_o;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    sb_q.delete();
    repeat (2) cyc();
    reset_n_i = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit pre_en, input int k);
    bit ok;
    ok = !(pre_en && k >= FE);
    for (int j = 0; j <= k && j < 16; j++)
      if (rom_mem[j][RW-1:DW] != 4'h1 && rom_mem[j][RW-1:DW] != 4'h2) ok = 1'b0;
    if (k >= 16) ok = 1'b0;
    if (ok) sb_q.push_back((rom_mem[k][RW-1:DW] == 4'h1 && rom_mem[k][DW-1:0] != d) ? 1 : 0);
    v_i = 1'b1;
    data_i = d;
    cyc();
    v_i = 1'b0;
  endtask

  task automatic pulse_en();
    en_i = 1'b1;
    cyc();
    en_i = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag, input bit rst);
    int k;
    for (int i = 0; i < 16; i++) rom_mem[i] = (i < 10) ? v.rom[i] : '0;
    if (rst) do_reset();
    k = 0;
    if (v.pre_en) begin
      for (int i = 0; i < v.n_rsp; i++) begin send(v.rsp[i], 1'b1, k); k++; end
      pulse_en();
    end else begin
      pulse_en();
      for (int i = 0; i < v.n_rsp; i++) begin
        send(v.rsp[i], 1'b0, k);
        k++;
        repeat (v.gap - 1) cyc();
      end
    end
    for (int i = 0; i < 500 && !done_o; i++) cyc();
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    repeat (6) cyc();
    chk({tag, "_check_count"}, 64'(check_count_o), 64'(v.e_check));
    chk({tag, "_mismatch_count"}, 64'(mismatch_count_o), 64'(v.e_mis));
    chk({tag, "_error"}, 64'(error_o), 64'(v.e_err));
    chk({tag, "_overflow"}, 64'(overflow_o), 64'(v.e_ovf));
    chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_error"}, 64'(error_o), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    chk({tag, "_check_count"}, 64'(check_count_o), 64'd0);
    chk({tag, "_mismatch_count"}, 64'(mismatch_count_o), 64'd0);
    chk({tag, "_rom_addr"}, 64'(rom_addr_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      vecs[i].rom = '0; vecs[i].rsp = '0; vecs[i].n_rsp = 0;
      vecs[i].pre_en = 1'b0; vecs[i].gap = 5;
    end
    // in-order matching compares
    vecs[0].rom[0] = ent(4'h1, 64'hA); vecs[0].rom[1] = ent(4'h1, 64'hB);
    vecs[0].n_rsp = 2; vecs[0].rsp[0] = 64'hA; vecs[0].rsp[1] = 64'hB;
    vecs[0].e_check = 2; vecs[0].e_mis = 0; vecs[0].e_err = 0; vecs[0].e_ovf = 0;
    // mismatch then skip
    vecs[1].rom[0] = ent(4'h1, 64'h5); vecs[1].rom[1] = ent(4'h2, 64'h0);
    vecs[1].n_rsp = 2; vecs[1].rsp[0] = 64'h6; vecs[1].rsp[1] = 64'hFF;
    vecs[1].e_check = 2; vecs[1].e_mis = 1; vecs[1].e_err = 1; vecs[1].e_ovf = 0;
    // nine back-to-back responses while idle
    for (int i = 0; i < 9; i++) vecs[2].rsp[i] = 64'h100 + 64'(i);
    for (int i = 0; i < 8; i++) vecs[2].rom[i] = ent(4'h1, 64'h100 + 64'(i));
    vecs[2].n_rsp = 9; vecs[2].pre_en = 1'b1;
    vecs[2].e_check = 8; vecs[2].e_mis = 0; vecs[2].e_err = 1; vecs[2].e_ovf = 1;
    // extra response after the finish entry
    vecs[3].rom[0] = ent(4'h1, 64'h1);
    vecs[3].n_rsp = 2; vecs[3].rsp[0] = 64'h1; vecs[3].rsp[1] = 64'h2;
    vecs[3].e_check = 1; vecs[3].e_mis = 0; vecs[3].e_err = 1; vecs[3].e_ovf = 0;
    // bad op at address 0
    vecs[4].rom[0] = ent(4'h7, 64'h0);
    vecs[4].e_check = 0; vecs[4].e_mis = 0; vecs[4].e_err = 1; vecs[4].e_ovf = 0;

    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
    cyc();
    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 5; i++) apply(vecs[i], $sformatf("vec%0d", i), 1'b1);

    // Reset while CHECK holds three queued responses that would mismatch vec0 if they survived.
    for (int i = 0; i < 16; i++) rom_mem[i] = (i < 10) ? vecs[0].rom[i] : '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = 64'h55 + 64'(i); cyc();
    end
    v_i = 1'b0;
    pulse_en();
    repeat (2) cyc();
    reset_n_i = 1'b0;
    sb_q.delete();
    cyc();
    reset_n_i = 1'b1;
    chk_zero("midreset");
    apply(vecs[0], "rerun", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

endmodule
